osc_capture_ctrl: RTL and testbench

- Trigger and capture sequencer for the oscilloscope acquisition path. Sits directly upstream of the FIFO write port.
- Takes the ADC sample stream, decimates it, waits for a level/edge trigger, then writes a programmed number of samples into the FIFO via w_en/wdata.
- Obeys the FIFO's registered wfull flag and reports completion to the reader side through done and overflow.

---
 rtl/osc_capture_ctrl.sv | 150 +++++++++++++++
 tb/tb_osc_capture_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_capture_ctrl.sv
// Trigger and capture sequencer: decimates the ADC stream, waits for a level/edge
// or forced trigger, then writes cap_len samples into the FIFO write port.
module osc_capture_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 10,
   parameter int DEC_WIDTH  = 16
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [DATA_WIDTH-1:0] adc_data,
   input  logic                  adc_valid,
   input  logic                  arm,
   input  logic                  trig_edge,
   input  logic [DATA_WIDTH-1:0] trig_level,
   input  logic                  trig_force,
   input  logic [DEC_WIDTH-1:0]  decim,
   input  logic [LEN_WIDTH-1:0]  cap_len,
   input  logic                  wfull,
   output logic                  w_en,
   output logic [DATA_WIDTH-1:0] wdata,
   output logic                  busy,
   output logic                  triggered,
   output logic                  done,
   output logic                  overflow,
   output logic [LEN_WIDTH-1:0]  sample_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_TRIG,
      S_CAPTURE,
      S_DONE
   } state_t;

   localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
   localparam logic [DEC_WIDTH-1:0] DEC_ONE = DEC_WIDTH'(1);

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [DEC_WIDTH-1:0]    r_decim;
   logic [LEN_WIDTH-1:0]    r_cap_len;
   logic [DEC_WIDTH-1:0]    r_dec_cnt;
   logic [DATA_WIDTH-1:0]   r_prev;
   logic                    r_prev_valid;
   logic                    r_triggered;
   logic                    r_overflow;
   logic [LEN_WIDTH-1:0]    r_sample_cnt;
   logic                    r_w_en;
   logic [DATA_WIDTH-1:0]   r_wdata;

   logic                    w_active;
   logic                    w_arm_ok;
   logic                    w_taken;
   logic                    w_rise;
   logic                    w_fall;
   logic                    w_fire;
   logic                    w_cap;
   logic                    w_last;
   logic [LEN_WIDTH-1:0]    w_cnt_inc;
   logic [LEN_WIDTH-1:0]    w_len_eff;

   always_comb begin
      w_active  = (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
      w_arm_ok  = ((r_state == S_IDLE) || (r_state == S_DONE)) && arm;
      w_taken   = w_active && adc_valid && (r_dec_cnt == '0);
      w_rise    = r_prev_valid && (r_prev < trig_level) && (adc_data >= trig_level);
      w_fall    = r_prev_valid && (r_prev > trig_level) && (adc_data <= trig_level);
      w_fire    = (r_state == S_WAIT_TRIG) && w_taken &&
                  (trig_force || (trig_edge ? w_fall : w_rise));
      // the trigger sample is itself the first capture sample
      w_cap     = w_taken && ((r_state == S_CAPTURE) || w_fire);
      w_cnt_inc = r_sample_cnt + LEN_ONE;
      w_last    = w_cap && (w_cnt_inc == r_cap_len);
      w_len_eff = (cap_len == '0) ? LEN_ONE : cap_len;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:      if (arm) w_state_nxt = S_WAIT_TRIG;
         S_WAIT_TRIG: begin
            if (w_last)      w_state_nxt = S_DONE;
            else if (w_fire) w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:      if (arm) w_state_nxt = S_WAIT_TRIG;
         default:     w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         r_decim      <= '0;
         r_cap_len    <= '0;
         r_dec_cnt    <= '0;
         r_prev       <= '0;
         r_prev_valid <= 1'b0;
         r_triggered  <= 1'b0;
         r_overflow   <= 1'b0;
         r_sample_cnt <= '0;
         r_w_en       <= 1'b0;
         r_wdata      <= '0;
      end else begin
         r_w_en <= 1'b0;
         if (w_arm_ok) begin
            r_decim      <= decim;
            r_cap_len    <= w_len_eff;
            r_dec_cnt    <= '0;
            r_prev_valid <= 1'b0;
            r_triggered  <= 1'b0;
            r_overflow   <= 1'b0;
            r_sample_cnt <= '0;
         end else if (w_active) begin
            if (adc_valid) begin
               r_dec_cnt <= w_taken ? r_decim : (r_dec_cnt - DEC_ONE);
            end
            if (w_taken && (r_state == S_WAIT_TRIG)) begin
               r_prev       <= adc_data;
               r_prev_valid <= 1'b1;
            end
            if (w_fire) r_triggered <= 1'b1;
            // sample_cnt stops at cap_len because the FSM leaves CAPTURE on that edge
            if (w_cap) begin
               if (!wfull) begin
                  r_w_en  <= 1'b1;
                  r_wdata <= adc_data;
               end else begin
                  r_overflow <= 1'b1;
               end
               r_sample_cnt <= w_cnt_inc;
            end
         end
      end
   end

   assign w_en       = r_w_en;
   assign wdata      = r_wdata;
   assign busy       = (r_state == S_WAIT_TRIG) || (r_state == S_CAPTURE);
   assign done       = (r_state == S_DONE);
   assign triggered  = r_triggered;
   assign overflow   = r_overflow;
   assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_osc_capture_ctrl.sv
// Bench for osc_capture_ctrl: directed vector table, hand sequences for corner cases,
// and randomized traffic checked every cycle against a sample-counting reference model.
module tb_osc_capture_ctrl;

   localparam int DW   = 8;
   localparam int LW   = 10;
   localparam int DECW = 16;

   logic            wclk = 1'b0;
   logic            wrst_n;
   logic [DW-1:0]   adc_data;
   logic            adc_valid;
   logic            arm;
   logic            trig_edge;
   logic [DW-1:0]   trig_level;
   logic            trig_force;
   logic [DECW-1:0] decim;
   logic [LW-1:0]   cap_len;
   logic            wfull;
   logic            w_en;
   logic [DW-1:0]   wdata;
   logic            busy;
   logic            triggered;
   logic            done;
   logic            overflow;
   logic [LW-1:0]   sample_cnt;

   always #5 wclk = ~wclk;

   osc_capture_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .DEC_WIDTH(DECW)) dut (
      .wclk(wclk), .wrst_n(wrst_n), .adc_data(adc_data), .adc_valid(adc_valid),
      .arm(arm), .trig_edge(trig_edge), .trig_level(trig_level), .trig_force(trig_force),
      .decim(decim), .cap_len(cap_len), .wfull(wfull), .w_en(w_en), .wdata(wdata),
      .busy(busy), .triggered(triggered), .done(done), .overflow(overflow),
      .sample_cnt(sample_cnt)
   );

   int checks = 0;
   int errors = 0;
   int wq[$];

   // reference model: phase 0 idle, 1 waiting, 2 capturing, 3 done
   int m_phase, m_dec, m_len, m_nv, m_prev, m_cnt, m_wdata;
   bit m_pv, m_trig, m_ovf, m_wen;

   typedef struct {
      logic a, v;
      int   d;
      logic f, full;
      logic e_wen;
      int   e_wdata;
      logic e_trig, e_busy, e_done, e_ovf;
      int   e_cnt;
   } vec_t;
   vec_t tv[8];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit taken, cap, fire;
      int d, lvl;
      d   = int'(adc_data);
      lvl = int'(trig_level);
      if (!wrst_n) begin
         m_phase = 0; m_wen = 0; m_wdata = 0; m_trig = 0; m_ovf = 0;
         m_cnt = 0; m_pv = 0; m_prev = 0; m_nv = 0;
      end else begin
         m_wen = 0;
         if ((m_phase == 0 || m_phase == 3) && arm) begin
            m_phase = 1; m_dec = int'(decim);
            m_len = (cap_len == 0) ? 1 : int'(cap_len);
            m_nv = 0; m_pv = 0; m_trig = 0; m_ovf = 0; m_cnt = 0;
         end else if ((m_phase == 1 || m_phase == 2) && adc_valid) begin
            taken = (m_nv % (m_dec + 1)) == 0;
            m_nv++;
            if (taken) begin
               cap = (m_phase == 2);
               if (m_phase == 1) begin
                  fire = trig_force || (m_pv && (trig_edge ? (m_prev > lvl && d <= lvl)
                                                           : (m_prev < lvl && d >= lvl)));
                  m_prev = d; m_pv = 1;
                  if (fire) begin cap = 1; m_phase = 2; m_trig = 1; end
               end
               if (cap) begin
                  if (!wfull) begin m_wen = 1; m_wdata = d; end
                  else m_ovf = 1;
                  m_cnt++;
                  if (m_cnt == m_len) m_phase = 3;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge wclk);
      model_edge();
      #1;
      chk("m_w_en", int'(w_en), int'(m_wen));
      if (m_wen) chk("m_wdata", int'(wdata), m_wdata);
      chk("m_busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
      chk("m_done", int'(done), int'(m_phase == 3));
      chk("m_triggered", int'(triggered), int'(m_trig));
      chk("m_overflow", int'(overflow), int'(m_ovf));
      chk("m_sample_cnt", int'(sample_cnt), m_cnt);
      if (w_en) wq.push_back(int'(wdata));
   endtask

   task automatic cyc(input logic a, input logic v, input int d, input logic f, input logic full);
      arm = a; adc_valid = v; adc_data = DW'(d); trig_force = f; wfull = full;
      step();
   endtask

   task automatic do_reset();
      wrst_n = 1'b0;
      cyc(0, 0, 0, 0, 0);
      wrst_n = 1'b1;
      wq.delete();
   endtask

   task automatic setcfg(input int dc, input int ln, input int lvl, input logic edg);
      decim = DECW'(dc); cap_len = LW'(ln); trig_level = DW'(lvl); trig_edge = edg;
   endtask

   initial begin
      tv[0] = '{1,0,'h00,0,0, 0,0,    0,1,0,0,0};
      tv[1] = '{0,1,'h7C,0,0, 0,0,    0,1,0,0,0};
      tv[2] = '{0,1,'h7E,0,0, 0,0,    0,1,0,0,0};
      tv[3] = '{0,1,'h80,0,0, 1,'h80, 1,1,0,0,1};
      tv[4] = '{0,1,'h82,0,0, 1,'h82, 1,1,0,0,2};
      tv[5] = '{0,1,'h84,0,0, 1,'h84, 1,1,0,0,3};
      tv[6] = '{0,1,'h86,0,0, 1,'h86, 1,0,1,0,4};
      tv[7] = '{0,0,'h00,0,0, 0,0,    1,0,1,0,4};

      setcfg(0, 0, 0, 0);
      do_reset();
      chk("reset_w_en", int'(w_en), 0);
      chk("reset_wdata", int'(wdata), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_sample_cnt", int'(sample_cnt), 0);

      // rising-edge trigger ramp
      setcfg(0, 4, 'h80, 0);
      foreach (tv[i]) begin
         cyc(tv[i].a, tv[i].v, tv[i].d, tv[i].f, tv[i].full);
         chk($sformatf("t1_w_en[%0d]", i), int'(w_en), int'(tv[i].e_wen));
         if (tv[i].e_wen) chk($sformatf("t1_wdata[%0d]", i), int'(wdata), tv[i].e_wdata);
         chk($sformatf("t1_trig[%0d]", i), int'(triggered), int'(tv[i].e_trig));
         chk($sformatf("t1_busy[%0d]", i), int'(busy), int'(tv[i].e_busy));
         chk($sformatf("t1_done[%0d]", i), int'(done), int'(tv[i].e_done));
         chk($sformatf("t1_ovf[%0d]", i), int'(overflow), int'(tv[i].e_ovf));
         chk($sformatf("t1_cnt[%0d]", i), int'(sample_cnt), tv[i].e_cnt);
      end

      // decimation by 3 with forced trigger
      do_reset();
      setcfg(2, 3, 0, 0);
      cyc(1, 0, 0, 1, 0);
      for (int s = 0; s < 9; s++) cyc(0, 1, s, 1, 0);
      cyc(0, 0, 0, 0, 0);
      chk("t2_writes", wq.size(), 3);
      if (wq.size() == 3) begin
         chk("t2_wdata0", wq[0], 0);
         chk("t2_wdata1", wq[1], 3);
         chk("t2_wdata2", wq[2], 6);
      end
      chk("t2_done", int'(done), 1);

      // falling edge; first sample cannot trigger
      do_reset();
      setcfg(0, 2, 'h40, 1);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 'h30, 0, 0);
      cyc(0, 1, 'h50, 0, 0);
      chk("t3_no_trig", int'(triggered), 0);
      cyc(0, 1, 'h40, 0, 0);
      chk("t3_trig", int'(triggered), 1);
      cyc(0, 1, 'h3F, 0, 0);
      chk("t3_first_wdata", (wq.size() > 0) ? wq[0] : -1, 'h40);

      // FIFO full on 2nd and 3rd samples
      do_reset();
      setcfg(0, 5, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int s = 0; s < 5; s++) cyc(0, 1, 'h10 + s, 1, (s == 1 || s == 2));
      cyc(0, 0, 0, 0, 0);
      chk("t4_writes", wq.size(), 3);
      chk("t4_overflow", int'(overflow), 1);
      chk("t4_cnt", int'(sample_cnt), 5);
      chk("t4_done", int'(done), 1);

      // reset mid-capture, then re-arm from DONE
      do_reset();
      setcfg(0, 8, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int s = 0; s < 3; s++) cyc(0, 1, s, 1, 0);
      wrst_n = 1'b0;
      cyc(0, 1, 'h77, 1, 0);
      wrst_n = 1'b1;
      chk("t5_rst_w_en", int'(w_en), 0);
      chk("t5_rst_busy", int'(busy), 0);
      chk("t5_rst_trig", int'(triggered), 0);
      chk("t5_rst_cnt", int'(sample_cnt), 0);
      cyc(0, 1, 'h55, 1, 0);
      chk("t5_idle_w_en", int'(w_en), 0);
      setcfg(0, 2, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 1, 1, 1);
      cyc(0, 1, 2, 1, 0);
      chk("t5_done", int'(done), 1);
      chk("t5_ovf", int'(overflow), 1);
      cyc(1, 0, 0, 0, 0);
      chk("t5_rearm_done", int'(done), 0);
      chk("t5_rearm_ovf", int'(overflow), 0);
      chk("t5_rearm_cnt", int'(sample_cnt), 0);
      chk("t5_rearm_busy", int'(busy), 1);

      // arm ignored while busy; cap_len 0 captures one sample
      do_reset();
      setcfg(0, 3, 'h80, 0);
      cyc(1, 0, 0, 0, 0);
      setcfg(3, 5, 'h80, 0);
      cyc(1, 1, 'h10, 0, 0);
      cyc(1, 1, 'h90, 0, 0);
      cyc(1, 1, 'h91, 0, 0);
      cyc(1, 1, 'h92, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("t6_writes", wq.size(), 3);
      chk("t6_cnt", int'(sample_cnt), 3);
      setcfg(0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 'h33, 1, 0);
      cyc(0, 1, 'h44, 1, 0);
      chk("t6_len0_writes", wq.size(), 4);
      chk("t6_len0_wdata", wq[wq.size()-1], 'h33);
      chk("t6_len0_cnt", int'(sample_cnt), 1);
      chk("t6_len0_done", int'(done), 1);

      // maximum capture length
      do_reset();
      setcfg(0, 1023, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int s = 0; s < 1023; s++) cyc(0, 1, s & 'hFF, 1, 0);
      cyc(0, 1, 0, 1, 0);
      chk("tmax_writes", wq.size(), 1023);
      chk("tmax_cnt", int'(sample_cnt), 1023);
      chk("tmax_done", int'(done), 1);

      // randomized traffic
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            setcfg($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 255),
                   1'($urandom_range(0, 1)));
         end
         wrst_n = ($urandom_range(0, 299) != 0);
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 255),
             $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
      end
      wrst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
